and_gate_share_arb: RTL and testbench



---
 rtl/and_gate_share_arb.sv | 155 +++++++++++++++
 tb/tb_and_gate_share_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_gate_share_arb.sv
// Round-robin arbiter sharing one registered-operand and_gate among N requesters.
// Define AND_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority; IDW must equal $clog2(N).

module and_gate (
    input  logic A,
    input  logic B,
    output logic Y
);
    assign Y = A & B;
endmodule

module and_gate_share_arb #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   A_in,
    input  logic [N-1:0]   B_in,
    output logic [N-1:0]   gnt,
    output logic           Y_out,
    output logic           Y_valid,
    output logic [IDW-1:0] Y_id,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           a_r_q, a_r_d;
    logic           b_r_q, b_r_d;
    logic           y_out_q, y_out_d;
    logic           y_valid_q, y_valid_d;
    logic [IDW-1:0] y_id_q, y_id_d;
    logic [IDW-1:0] win_q, win_d;
    logic [IDW-1:0] pick;
    logic           gate_y;
`ifndef AND_ARB_FIXED_PRI_EN
    logic [IDW-1:0] last_q, last_d;
`endif

    and_gate u_and_gate (
        .A (a_r_q),
        .B (b_r_q),
        .Y (gate_y)
    );

`ifdef AND_ARB_FIXED_PRI_EN
    // Downward scan so the lowest asserted index is the last (winning) write.
    always_comb begin : p_pick
        pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) pick = IDW'(i);
        end
    end
`else
    always_comb begin : p_pick
        logic           found;
        logic [IDW-1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IDW'((int'(last_q) + off) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end
`endif

    // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin : p_next
        state_d   = state_q;
        gnt_d     = gnt_q;
        a_r_d     = a_r_q;
        b_r_d     = b_r_q;
        y_out_d   = y_out_q;
        y_valid_d = y_valid_q;
        y_id_d    = y_id_q;
        win_d     = win_q;
`ifndef AND_ARB_FIXED_PRI_EN
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    a_r_d   = A_in[pick];
                    b_r_d   = B_in[pick];
                    gnt_d   = N'(1) << pick;
                    win_d   = pick;
`ifndef AND_ARB_FIXED_PRI_EN
                    last_d  = pick;
`endif
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                y_out_d   = gate_y;
                y_id_d    = win_q;
                y_valid_d = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                y_valid_d = 1'b0;
                gnt_d     = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            a_r_q     <= 1'b0;
            b_r_q     <= 1'b0;
            y_out_q   <= 1'b0;
            y_valid_q <= 1'b0;
            y_id_q    <= '0;
            win_q     <= '0;
`ifndef AND_ARB_FIXED_PRI_EN
            last_q    <= IDW'(N - 1);
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            a_r_q     <= a_r_d;
            b_r_q     <= b_r_d;
            y_out_q   <= y_out_d;
            y_valid_q <= y_valid_d;
            y_id_q    <= y_id_d;
            win_q     <= win_d;
`ifndef AND_ARB_FIXED_PRI_EN
            last_q    <= last_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign Y_out   = y_out_q;
    assign Y_valid = y_valid_q;
    assign Y_id    = y_id_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_and_gate_share_arb.sv
// Self-checking bench for and_gate_share_arb: directed scenarios plus randomized ops against a queue-free reference model.
module tb_and_gate_share_arb;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, A_in, B_in;
    logic [N-1:0]   gnt;
    logic           Y_out, Y_valid, busy;
    logic [IDW-1:0] Y_id;

    and_gate_share_arb #(.N(N), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .A_in(A_in), .B_in(B_in),
        .gnt(gnt), .Y_out(Y_out), .Y_valid(Y_valid), .Y_id(Y_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_last;

    always @(posedge clk) cyc++;

    // Observations captured by issue() at each phase of one operation
    logic [N-1:0]   o_gnt1, o_gnt2, o_gnt3;
    logic           o_v1, o_v2, o_v3, o_y, o_b1, o_b3;
    logic [IDW-1:0] o_id;
    int             o_vcyc;

    // Reference winner choice straight from the arbitration rule
    function automatic int predict(input logic [N-1:0] r, input int last);
`ifdef AND_ARB_FIXED_PRI_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int off = 1; off <= N; off++) begin
            int idx;
            idx = (last + off) % N;
            if (r[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full op from IDLE; optionally scrambles inputs during EVAL and drops the owner's req on Y_valid.
    task automatic issue(input logic [N-1:0] r, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit scramble, input bit drop);
        req  = r;
        A_in = a;
        B_in = b;
        tick();
        o_gnt1 = gnt; o_v1 = Y_valid; o_b1 = busy;
        if (scramble) begin
            A_in = N'($urandom);
            B_in = N'($urandom);
            req  = N'($urandom);
        end
        tick();
        o_gnt2 = gnt; o_v2 = Y_valid; o_y = Y_out; o_id = Y_id; o_vcyc = cyc;
        if (drop) req[Y_id] = 1'b0;
        tick();
        o_gnt3 = gnt; o_v3 = Y_valid; o_b3 = busy;
    endtask

    task automatic test_reset();
        int w;
        rst = 1'b1; req = '1; A_in = '1; B_in = '1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({gnt, Y_out, Y_valid, Y_id, busy} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got gnt=%b y=%b v=%b id=%0d busy=%b, want all 0",
                         gnt, Y_out, Y_valid, Y_id, busy);
            end
        end
        rst = 1'b0;
        exp_last = N - 1;
        w = predict(4'b1111, exp_last);
        issue(4'b1111, '1, '1, 0, 1);
        req = '0;
        total++;
        if (o_gnt1 !== 4'b0001) begin
            bad++;
            $display("FAIL reset_first_grant: got %b want 0001", o_gnt1);
        end
        exp_last = w;
    endtask

    task automatic test_single();
        issue(4'b0100, 4'b0100, 4'b0100, 0, 1);
        req = '0;
        total++;
        if (o_gnt1 !== 4'b0100 || o_b1 !== 1'b1 || o_v1 !== 1'b0) begin
            bad++;
            $display("FAIL single_grant: got gnt=%b busy=%b v=%b want 0100/1/0", o_gnt1, o_b1, o_v1);
        end
        total++;
        if (o_v2 !== 1'b1 || o_y !== 1'b1 || o_id !== 2'd2 || o_gnt2 !== 4'b0100) begin
            bad++;
            $display("FAIL single_result: got v=%b y=%b id=%0d gnt=%b want 1/1/2/0100", o_v2, o_y, o_id, o_gnt2);
        end
        total++;
        if (o_v3 !== 1'b0 || o_gnt3 !== '0 || o_b3 !== 1'b0) begin
            bad++;
            $display("FAIL single_done: got v=%b gnt=%b busy=%b want 0/0000/0", o_v3, o_gnt3, o_b3);
        end
        tick();
        total++;
        if (Y_out !== 1'b1 || Y_id !== 2'd2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_hold: got y=%b id=%0d busy=%b want 1/2/0", Y_out, Y_id, busy);
        end
        exp_last = 2;
    endtask

    task automatic test_truth_table();
        for (int ab = 0; ab < 4; ab++) begin
            logic [N-1:0] a, b;
            a = N'($urandom); b = N'($urandom);
            a[1] = ab[1]; b[1] = ab[0];
            issue(4'b0010, a, b, 0, 1);
            req = '0;
            total++;
            if (o_y !== (ab[1] & ab[0]) || o_id !== 2'd1 || o_v2 !== 1'b1) begin
                bad++;
                $display("FAIL truth_ab%0d: got y=%b id=%0d v=%b want %b/1/1", ab, o_y, o_id, o_v2, ab[1] & ab[0]);
            end
        end
        exp_last = 1;
    endtask

    task automatic test_fairness();
        logic [N-1:0] r;
        int prev;
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        exp_last = N - 1;
        r = 4'b1111;
        prev = -1;
`ifdef AND_ARB_FIXED_PRI_EN
        for (int k = 0; k < 6; k++) begin
            issue(r, N'($urandom), N'($urandom), 0, 0);
            total++;
            if (o_id !== 2'd0 || (prev >= 0 && o_vcyc - prev != 3)) begin
                bad++;
                $display("FAIL fixed_pri_%0d: got id=%0d gap=%0d want 0/3", k, o_id, o_vcyc - prev);
            end
            prev = o_vcyc;
        end
`else
        for (int k = 0; k < N; k++) begin
            issue(r, N'($urandom), N'($urandom), 0, 1);
            r[k] = 1'b0;
            total++;
            if (o_id !== IDW'(k) || (prev >= 0 && o_vcyc - prev != 3)) begin
                bad++;
                $display("FAIL fairness_%0d: got id=%0d gap=%0d want %0d/3", k, o_id, o_vcyc - prev, k);
            end
            prev = o_vcyc;
        end
        exp_last = N - 1;
`endif
        req = '0;
    endtask

    task automatic test_operand_change();
        for (int k = 0; k < 6; k++) begin
            logic [N-1:0] r, a, b;
            int w;
            r = N'($urandom_range(1, 15));
            a = (k == 0) ? '1 : N'($urandom);
            b = (k == 0) ? '1 : N'($urandom);
            w = predict(r, exp_last);
            issue(r, a, b, 1, 1);
            req = '0;
            total++;
            if (o_y !== (a[w] & b[w]) || o_id !== IDW'(w)) begin
                bad++;
                $display("FAIL opchange_%0d: got y=%b id=%0d want %b/%0d", k, o_y, o_id, a[w] & b[w], w);
            end
`ifndef AND_ARB_FIXED_PRI_EN
            exp_last = w;
`endif
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b1000; A_in = '1; B_in = '1;
        tick();
        total++;
        if (gnt !== 4'b1000) begin
            bad++;
            $display("FAIL rstmid_grant: got %b want 1000", gnt);
        end
        rst = 1'b1; req = '0;
        tick();
        total++;
        if (Y_valid !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_abort: got v=%b gnt=%b busy=%b want 0/0000/0", Y_valid, gnt, busy);
        end
        rst = 1'b0;
        tick();
        total++;
        if (Y_valid !== 1'b0 || Y_out !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_novalid: got v=%b y=%b want 0/0", Y_valid, Y_out);
        end
        exp_last = N - 1;
        issue(4'b1111, '0, '0, 0, 1);
        req = '0;
        total++;
        if (o_id !== 2'd0 || o_gnt1 !== 4'b0001) begin
            bad++;
            $display("FAIL rstmid_restart: got id=%0d gnt=%b want 0/0001", o_id, o_gnt1);
        end
        exp_last = 0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] r, a, b, eg;
            int w, gap;
            gap = $urandom_range(0, 2);
            req = '0;
            for (int g = 0; g < gap; g++) begin
                tick();
                total++;
                if (busy !== 1'b0 || gnt !== '0 || Y_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_idle_%0d: got busy=%b gnt=%b v=%b want 0/0000/0", k, busy, gnt, Y_valid);
                end
            end
            r = N'($urandom_range(1, 15));
            a = N'($urandom);
            b = N'($urandom);
            w = predict(r, exp_last);
            eg = '0;
            eg[w] = 1'b1;
            issue(r, a, b, bit'($urandom_range(0, 1)), 1);
            total++;
            if (o_gnt1 !== eg || o_gnt2 !== eg || o_v2 !== 1'b1 || o_y !== (a[w] & b[w]) ||
                o_id !== IDW'(w) || o_v3 !== 1'b0 || o_gnt3 !== '0 || o_b3 !== 1'b0) begin
                bad++;
                $display("FAIL rand_op_%0d: got gnt=%b/%b/%b v=%b/%b y=%b id=%0d, want gnt=%b v=1/0 y=%b id=%0d",
                         k, o_gnt1, o_gnt2, o_gnt3, o_v2, o_v3, o_y, o_id, eg, a[w] & b[w], w);
            end
`ifndef AND_ARB_FIXED_PRI_EN
            exp_last = w;
`endif
        end
        req = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; A_in = '0; B_in = '0;
        test_reset();
        test_single();
        test_truth_table();
        test_fairness();
        test_operand_change();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
